hazard_sequencer: RTL and testbench



---
 rtl/hazard_sequencer_if.sv | 33 +++
 rtl/hazard_sequencer.sv | 131 +++++++++++++
 tb/tb_hazard_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : hazard_sequencer_if
// Brief  : Pipeline <-> hazard unit signal bundle (register ids, enables,
//          stall/flush/forward controls).
// Rev    : 1.0  initial release
// ============================================================================
interface hazard_sequencer_if;
  logic [4:0] Rs1D, Rs2D;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic       RegWriteE, ResultSrcE0, MduStartE, PCSrcE;
  logic [4:0] RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic       StallF, StallD, StallE;
  logic       FlushD, FlushE, FlushM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MduDoneE, MduBusy;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE0, MduStartE,
           PCSrcE, RdM, RdW, RegWriteM, RegWriteW,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
           ForwardAE, ForwardBE, MduDoneE, MduBusy
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE0, MduStartE,
           PCSrcE, RdM, RdW, RegWriteM, RegWriteW,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
           ForwardAE, ForwardBE, MduDoneE, MduBusy
  );
endinterface
`default_nettype wire

// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module : hazard_sequencer
// Brief  : Stall/flush/forwarding control and MDU sequencing for a 5-stage
//          RV32I pipeline. Macro HAZARD_FORWARDING_EN selects EX forwarding
//          with load-use stall; otherwise a full RAW interlock is used.
// Rev    : 1.0  initial release
// ============================================================================
module hazard_sequencer #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic             clock,
  input  logic             reset,
  hazard_sequencer_if.slave bus
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_INIT =
    CNT_W'((MDU_LATENCY > 1) ? (MDU_LATENCY - 2) : 0);
  localparam bit c_MDU_MULTI = (MDU_LATENCY > 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_hazard;
  logic [1:0]       w_fwd_a, w_fwd_b;

`ifdef HAZARD_FORWARDING_EN
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wm,
                                         input logic [4:0] rdm, input logic ww,
                                         input logic [4:0] rdw);
    if (wm && rdm != 5'd0 && rdm == rs)      fwd_sel = 2'b10;
    else if (ww && rdw != 5'd0 && rdw == rs) fwd_sel = 2'b01;
    else                                     fwd_sel = 2'b00;
  endfunction

  assign w_fwd_a  = fwd_sel(bus.Rs1E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
  assign w_fwd_b  = fwd_sel(bus.Rs2E, bus.RegWriteM, bus.RdM, bus.RegWriteW, bus.RdW);
  assign w_hazard = bus.ResultSrcE0 && (bus.RdE != 5'd0) &&
                    ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
`else
  // Without forwarding, any in-flight writer in EX or MEM blocks the ID read.
  logic w_unused;
  assign w_unused = ^{bus.Rs1E, bus.Rs2E, bus.RdW, bus.RegWriteW, bus.ResultSrcE0};
  assign w_fwd_a  = 2'b00;
  assign w_fwd_b  = 2'b00;
  assign w_hazard =
    (bus.RegWriteE && (bus.RdE != 5'd0) &&
     ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D))) ||
    (bus.RegWriteM && (bus.RdM != 5'd0) &&
     ((bus.RdM == bus.Rs1D) || (bus.RdM == bus.Rs2D)));
`endif

  always_comb begin
    bus.StallF    = 1'b0;
    bus.StallD    = 1'b0;
    bus.StallE    = 1'b0;
    bus.FlushD    = 1'b0;
    bus.FlushE    = 1'b0;
    bus.FlushM    = 1'b0;
    bus.ForwardAE = 2'b00;
    bus.ForwardBE = 2'b00;
    bus.MduDoneE  = 1'b0;
    bus.MduBusy   = 1'b0;
    if (reset) begin
      bus.ForwardAE = w_fwd_a;
      bus.ForwardBE = w_fwd_b;
      case (r_state)
        S_RUN: begin
          if (bus.PCSrcE) begin
            bus.FlushD = 1'b1;
            bus.FlushE = 1'b1;
          end else if (bus.MduStartE) begin
            if (c_MDU_MULTI) begin
              bus.StallF = 1'b1;
              bus.StallD = 1'b1;
              bus.StallE = 1'b1;
              bus.FlushM = 1'b1;
            end else begin
              bus.MduDoneE = 1'b1;
            end
          end else if (w_hazard) begin
            bus.StallF = 1'b1;
            bus.StallD = 1'b1;
            bus.FlushE = 1'b1;
          end
        end
        S_WAIT: begin
          // Redirects and hazards are deferred so the MDU op is never killed.
          bus.MduBusy = 1'b1;
          if (r_cnt != '0) begin
            bus.StallF = 1'b1;
            bus.StallD = 1'b1;
            bus.StallE = 1'b1;
            bus.FlushM = 1'b1;
          end else begin
            bus.MduDoneE = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (!bus.PCSrcE && bus.MduStartE && c_MDU_MULTI) begin
            r_state <= S_WAIT;
            r_cnt   <= c_CNT_INIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else             r_state <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_sequencer
// Brief  : Directed stimulus with expected-output queue and negedge monitor.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hazard_sequencer;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  hazard_sequencer_if hif ();

  hazard_sequencer #(.MDU_LATENCY(4), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (hif.slave)
  );

  typedef struct {
    string      name;
    logic [11:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // {StallF,StallD,StallE,FlushD,FlushE,FlushM,FwdA,FwdB,Done,Busy}
  function automatic logic [11:0] mk(bit sf, bit sd, bit se, bit fd, bit fe,
                                     bit fm, bit [1:0] fa, bit [1:0] fb,
                                     bit dn, bit bs);
    return {sf, sd, se, fd, fe, fm, fa, fb, dn, bs};
  endfunction

  logic [11:0] w_act;
  assign w_act = {hif.StallF, hif.StallD, hif.StallE, hif.FlushD, hif.FlushE,
                  hif.FlushM, hif.ForwardAE, hif.ForwardBE, hif.MduDoneE,
                  hif.MduBusy};

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (w_act !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got %b expected %b", e.name, w_act, e.exp);
      end
    end
  end

  task automatic clr();
    hif.Rs1D = 5'd0; hif.Rs2D = 5'd0; hif.Rs1E = 5'd0; hif.Rs2E = 5'd0;
    hif.RdE = 5'd0; hif.RegWriteE = 1'b0; hif.ResultSrcE0 = 1'b0;
    hif.MduStartE = 1'b0; hif.PCSrcE = 1'b0; hif.RdM = 5'd0; hif.RdW = 5'd0;
    hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(string nm, logic [11:0] e);
    exp_t x;
    x.name = nm;
    x.exp  = e;
    q.push_back(x);
  endtask

  localparam logic [11:0] ZERO = 12'b0;
  localparam logic [11:0] S3M  = 12'b1110_0100_0000;
  localparam logic [11:0] LUS  = 12'b1100_1000_0000;
  localparam logic [11:0] RED  = 12'b0001_1000_0000;

  initial begin
    clr();
    // Reset held with conflicting requests
    next();
    hif.PCSrcE = 1'b1; hif.MduStartE = 1'b1;
    hif.RegWriteM = 1'b1; hif.RdM = 5'd5; hif.Rs1E = 5'd5;
    expect_out("reset_hold0", ZERO);
    next();
    expect_out("reset_hold1", ZERO);

    next();
    clr(); reset = 1'b1;
    expect_out("reset_release", ZERO);

    // Forwarding
    next();
    hif.RegWriteM = 1'b1; hif.RdM = 5'd5; hif.RegWriteW = 1'b1; hif.RdW = 5'd5;
    hif.Rs1E = 5'd5;
    expect_out("fwd_mem_prio", mk(0,0,0,0,0,0, FWD ? 2'b10 : 2'b00, 2'b00, 0,0));
    next();
    hif.RdM = 5'd0;
    expect_out("fwd_wb", mk(0,0,0,0,0,0, FWD ? 2'b01 : 2'b00, 2'b00, 0,0));
    next();
    hif.Rs1E = 5'd0; hif.RdW = 5'd0; hif.Rs2E = 5'd0;
    expect_out("fwd_x0", ZERO);
    next();
    hif.RdW = 5'd9; hif.Rs2E = 5'd9; hif.RdM = 5'd4; hif.Rs1E = 5'd4;
    expect_out("fwd_a_mem_b_wb",
               mk(0,0,0,0,0,0, FWD ? 2'b10 : 2'b00, FWD ? 2'b01 : 2'b00, 0,0));

    // Load-use
    next();
    clr();
    hif.ResultSrcE0 = 1'b1; hif.RegWriteE = 1'b1; hif.RdE = 5'd7; hif.Rs2D = 5'd7;
    expect_out("load_use", LUS);
    next();
    hif.PCSrcE = 1'b1;
    expect_out("lu_with_redirect", RED);
    next();
    clr();
    hif.ResultSrcE0 = 1'b1; hif.RegWriteE = 1'b1; hif.RdE = 5'd0; hif.Rs2D = 5'd0;
    expect_out("lu_rd_x0", ZERO);

    // RAW interlock (only stalls without forwarding)
    next();
    clr();
    hif.RegWriteE = 1'b1; hif.RdE = 5'd3; hif.Rs1D = 5'd3;
    expect_out("raw_ex", FWD ? ZERO : LUS);
    next();
    hif.RegWriteE = 1'b0; hif.RdE = 5'd0; hif.RegWriteM = 1'b1; hif.RdM = 5'd3;
    expect_out("raw_mem", FWD ? ZERO : LUS);
    next();
    hif.RdM = 5'd8;
    expect_out("raw_clear", ZERO);

    // MDU op with deferred redirect / hazard
    next();
    clr();
    hif.MduStartE = 1'b1;
    expect_out("mdu_c0", S3M);
    next();
    hif.PCSrcE = 1'b1; hif.ResultSrcE0 = 1'b1; hif.RegWriteE = 1'b1;
    hif.RdE = 5'd7; hif.Rs2D = 5'd7;
    expect_out("mdu_c1_ignore", S3M | 12'b1);
    next();
    expect_out("mdu_c2_ignore", S3M | 12'b1);
    next();
    hif.PCSrcE = 1'b0; hif.ResultSrcE0 = 1'b0; hif.RegWriteE = 1'b0;
    hif.RdE = 5'd0; hif.Rs2D = 5'd0;
    expect_out("mdu_c3_done", 12'b0000_0000_0011);
    next();
    hif.MduStartE = 1'b0;
    hif.ResultSrcE0 = 1'b1; hif.RegWriteE = 1'b1; hif.RdE = 5'd7; hif.Rs2D = 5'd7;
    expect_out("post_mdu_lu", LUS);

    // Reset during WAIT
    next();
    clr();
    hif.MduStartE = 1'b1;
    expect_out("mdu2_c0", S3M);
    next();
    expect_out("mdu2_c1", S3M | 12'b1);
    next();
    #2 reset = 1'b0;
    expect_out("mdu2_reset", ZERO);
    next();
    reset = 1'b1; hif.MduStartE = 1'b0;
    expect_out("after_abort", ZERO);
    next();
    hif.MduStartE = 1'b1;
    expect_out("mdu3_c0_run", S3M);
    next();
    expect_out("mdu3_c1", S3M | 12'b1);
    next();
    expect_out("mdu3_c2", S3M | 12'b1);
    next();
    expect_out("mdu3_c3", 12'b0000_0000_0011);
    next();
    hif.MduStartE = 1'b0;
    expect_out("idle_end", ZERO);

    begin
      int guard = 0;
      while (q.size() > 0 && guard < 10) begin
        @(posedge clock);
        guard++;
      end
      if (q.size() > 0) begin
        n_errors++;
        n_checks++;
        $display("FAIL drain: got %0d pending expected 0", q.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
